// File: rtl/osd_cell_seq_if.sv
// Bus bundle for the OSD cell sequencer: line/field timing and per-field
// settings in, VRAM and font addressing plus window flags out.
interface osd_cell_seq_if #(
  parameter int C_COLS   = 32,
  parameter int C_ROWS   = 16,
  parameter int C_FONT_W = 8,
  parameter int C_FONT_H = 8,
  parameter int C_HDLY_W = 12,
  parameter int C_VDLY_W = 11
);
  logic                              HSTART_i;
  logic                              VSTART_i;
  logic                              PIX_EN_i;
  logic [C_HDLY_W-1:0]               BUS_H_DLYs_i;
  logic [C_VDLY_W-1:0]               BUS_V_DLYs_i;
  logic [2:0]                        BUS_H_MAGs_i;
  logic [2:0]                        BUS_V_MAGs_i;
  logic [$clog2(C_COLS)-1:0]         BUS_H_SCROLLs_i;
  logic [$clog2(C_ROWS)-1:0]         BUS_V_SCROLLs_i;
  logic                              BUS_OSD_OFF_i;
  logic [$clog2(C_COLS*C_ROWS)-1:0]  VRAM_RAs_o;
  logic [$clog2(C_FONT_H)-1:0]       FONT_ROWs_o;
  logic [$clog2(C_FONT_W)-1:0]       FONT_BITs_o;
  logic                              ACT_o;
  logic                              CELL_STB_o;
  logic                              FRAME_END_o;

  modport master (
    output HSTART_i, VSTART_i, PIX_EN_i, BUS_H_DLYs_i, BUS_V_DLYs_i,
           BUS_H_MAGs_i, BUS_V_MAGs_i, BUS_H_SCROLLs_i, BUS_V_SCROLLs_i,
           BUS_OSD_OFF_i,
    input  VRAM_RAs_o, FONT_ROWs_o, FONT_BITs_o, ACT_o, CELL_STB_o, FRAME_END_o
  );

  modport slave (
    input  HSTART_i, VSTART_i, PIX_EN_i, BUS_H_DLYs_i, BUS_V_DLYs_i,
           BUS_H_MAGs_i, BUS_V_MAGs_i, BUS_H_SCROLLs_i, BUS_V_SCROLLs_i,
           BUS_OSD_OFF_i,
    output VRAM_RAs_o, FONT_ROWs_o, FONT_BITs_o, ACT_o, CELL_STB_o, FRAME_END_o
  );
endinterface

// File: rtl/osd_cell_seq.sv
// Text-mode OSD cell sequencer: walks a C_COLS x C_ROWS character grid with
// per-field delay, magnification and scroll, producing VRAM and font addresses.
module osd_cell_seq #(
  parameter int C_COLS   = 32,
  parameter int C_ROWS   = 16,
  parameter int C_FONT_W = 8,
  parameter int C_FONT_H = 8,
  parameter int C_HDLY_W = 12,
  parameter int C_VDLY_W = 11
) (
  input  logic          CK_i,
  input  logic          SYS_R_i,
  osd_cell_seq_if.slave bus
);
  localparam int COL_W  = $clog2(C_COLS);
  localparam int ROW_W  = $clog2(C_ROWS);
  localparam int BIT_W  = $clog2(C_FONT_W);
  localparam int FROW_W = $clog2(C_FONT_H);
  localparam int RA_W   = COL_W + ROW_W;

  localparam logic [COL_W-1:0]    COL_LAST  = COL_W'(C_COLS - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST  = ROW_W'(C_ROWS - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(C_FONT_W - 1);
  localparam logic [FROW_W-1:0]   FROW_LAST = FROW_W'(C_FONT_H - 1);
  localparam logic [C_VDLY_W-1:0] LINE_SAT  = {C_VDLY_W{1'b1}};
  localparam logic [C_HDLY_W-1:0] PIX_SAT   = {C_HDLY_W{1'b1}};

  typedef enum logic [1:0] {VIDLE = 2'd0, VDLY = 2'd1, VACT = 2'd2, VDONE = 2'd3} v_state_t;
  typedef enum logic [1:0] {HIDLE = 2'd0, HDLY = 2'd1, HACT = 2'd2} h_state_t;

  v_state_t            v_state_r, v_state_s, v_base_s;
  h_state_t            h_state_r, h_state_s;
  logic [C_VDLY_W-1:0] line_cnt_r, line_cnt_s, line_base_s;
  logic [C_HDLY_W-1:0] pix_cnt_r, pix_cnt_s;
  logic [2:0]          vsub_r, vsub_s, hsub_r, hsub_s;
  logic [FROW_W-1:0]   frow_r, frow_s;
  logic [ROW_W-1:0]    row_r, row_s, row_sum_s;
  logic [BIT_W-1:0]    bit_r, bit_s;
  logic [COL_W-1:0]    col_r, col_s, col_sum_s;
  logic [C_HDLY_W-1:0] hdly_r, hdly_s;
  logic [C_VDLY_W-1:0] vdly_r, vdly_s;
  logic [2:0]          hmag_r, hmag_s, vmag_r, vmag_s;
  logic [COL_W-1:0]    hscr_r, hscr_s;
  logic [ROW_W-1:0]    vscr_r, vscr_s;
  logic                act_s, cell_stb_s, frame_end_s;
  logic                act_r, cell_stb_r, frame_end_r;
  logic [RA_W-1:0]     ra_r;
  logic [FROW_W-1:0]   font_row_r;
  logic [BIT_W-1:0]    font_bit_r;

  // The VSTART cycle already works with the new field settings.
  assign hdly_s = bus.VSTART_i ? bus.BUS_H_DLYs_i    : hdly_r;
  assign vdly_s = bus.VSTART_i ? bus.BUS_V_DLYs_i    : vdly_r;
  assign hmag_s = bus.VSTART_i ? bus.BUS_H_MAGs_i    : hmag_r;
  assign vmag_s = bus.VSTART_i ? bus.BUS_V_MAGs_i    : vmag_r;
  assign hscr_s = bus.VSTART_i ? bus.BUS_H_SCROLLs_i : hscr_r;
  assign vscr_s = bus.VSTART_i ? bus.BUS_V_SCROLLs_i : vscr_r;

  // Vertical sequencer: line delay, then sub-line/font-row/text-row walk.
  always_comb begin
    v_base_s    = bus.VSTART_i ? VDLY : v_state_r;
    line_base_s = bus.VSTART_i ? {C_VDLY_W{1'b0}} : line_cnt_r;
    v_state_s   = v_base_s;
    line_cnt_s  = line_base_s;
    vsub_s      = vsub_r;
    frow_s      = frow_r;
    row_s       = row_r;
    frame_end_s = 1'b0;
    if (bus.HSTART_i) begin
      case (v_base_s)
        VDLY: begin
          if (line_base_s == vdly_s) begin
            v_state_s = VACT;
            vsub_s    = 3'd0;
            frow_s    = {FROW_W{1'b0}};
            row_s     = {ROW_W{1'b0}};
          end else if (line_base_s != LINE_SAT) begin
            line_cnt_s = line_base_s + 1'b1;
          end else begin
            line_cnt_s = line_base_s;
          end
        end
        VACT: begin
          if (vsub_r != vmag_s) begin
            vsub_s = vsub_r + 1'b1;
          end else begin
            vsub_s = 3'd0;
            if (frow_r != FROW_LAST) begin
              frow_s = frow_r + 1'b1;
            end else begin
              frow_s = {FROW_W{1'b0}};
              if (row_r != ROW_LAST) begin
                row_s = row_r + 1'b1;
              end else begin
                v_state_s   = VDONE;
                frame_end_s = 1'b1;
              end
            end
          end
        end
        default: v_state_s = v_base_s;
      endcase
    end else begin
      v_state_s = v_base_s;
    end
  end

  // Horizontal sequencer: pixel delay, then sub-pixel/bit/column walk.
  always_comb begin
    h_state_s = h_state_r;
    pix_cnt_s = pix_cnt_r;
    hsub_s    = hsub_r;
    bit_s     = bit_r;
    col_s     = col_r;
    if (bus.HSTART_i) begin
      h_state_s = HDLY;
      pix_cnt_s = {C_HDLY_W{1'b0}};
    end else if (bus.PIX_EN_i) begin
      case (h_state_r)
        HDLY: begin
          if (pix_cnt_r == hdly_s) begin
            h_state_s = HACT;
            hsub_s    = 3'd0;
            bit_s     = {BIT_W{1'b0}};
            col_s     = {COL_W{1'b0}};
          end else if (pix_cnt_r != PIX_SAT) begin
            pix_cnt_s = pix_cnt_r + 1'b1;
          end else begin
            pix_cnt_s = pix_cnt_r;
          end
        end
        HACT: begin
          if (hsub_r != hmag_s) begin
            hsub_s = hsub_r + 1'b1;
          end else begin
            hsub_s = 3'd0;
            if (bit_r != BIT_LAST) begin
              bit_s = bit_r + 1'b1;
            end else begin
              bit_s = {BIT_W{1'b0}};
              if (col_r != COL_LAST) begin
                col_s = col_r + 1'b1;
              end else begin
                h_state_s = HIDLE;
              end
            end
          end
        end
        default: h_state_s = h_state_r;
      endcase
    end else begin
      h_state_s = h_state_r;
    end
  end

  // Window flags and scrolled cell address derived from the next state.
  always_comb begin
    act_s      = (h_state_s == HACT) && (v_state_s == VACT) && !bus.BUS_OSD_OFF_i;
    cell_stb_s = act_s && (bit_s == {BIT_W{1'b0}}) && (hsub_s == 3'd0);
    row_sum_s  = row_s + vscr_s;
    col_sum_s  = col_s + hscr_s;
  end

  // State, latched field settings and registered outputs.
  always_ff @(posedge CK_i) begin
    if (SYS_R_i) begin
      v_state_r   <= VIDLE;
      h_state_r   <= HIDLE;
      line_cnt_r  <= {C_VDLY_W{1'b0}};
      pix_cnt_r   <= {C_HDLY_W{1'b0}};
      vsub_r      <= 3'd0;
      hsub_r      <= 3'd0;
      frow_r      <= {FROW_W{1'b0}};
      row_r       <= {ROW_W{1'b0}};
      bit_r       <= {BIT_W{1'b0}};
      col_r       <= {COL_W{1'b0}};
      hdly_r      <= {C_HDLY_W{1'b0}};
      vdly_r      <= {C_VDLY_W{1'b0}};
      hmag_r      <= 3'd0;
      vmag_r      <= 3'd0;
      hscr_r      <= {COL_W{1'b0}};
      vscr_r      <= {ROW_W{1'b0}};
      act_r       <= 1'b0;
      cell_stb_r  <= 1'b0;
      frame_end_r <= 1'b0;
      ra_r        <= {RA_W{1'b0}};
      font_row_r  <= {FROW_W{1'b0}};
      font_bit_r  <= {BIT_W{1'b0}};
    end else begin
      v_state_r   <= v_state_s;
      h_state_r   <= h_state_s;
      line_cnt_r  <= line_cnt_s;
      pix_cnt_r   <= pix_cnt_s;
      vsub_r      <= vsub_s;
      hsub_r      <= hsub_s;
      frow_r      <= frow_s;
      row_r       <= row_s;
      bit_r       <= bit_s;
      col_r       <= col_s;
      hdly_r      <= hdly_s;
      vdly_r      <= vdly_s;
      hmag_r      <= hmag_s;
      vmag_r      <= vmag_s;
      hscr_r      <= hscr_s;
      vscr_r      <= vscr_s;
      act_r       <= act_s;
      cell_stb_r  <= cell_stb_s;
      frame_end_r <= frame_end_s;
      ra_r        <= act_s ? {row_sum_s, col_sum_s} : ra_r;
      font_row_r  <= act_s ? frow_s : font_row_r;
      font_bit_r  <= act_s ? bit_s  : font_bit_r;
    end
  end

  assign bus.ACT_o       = act_r;
  assign bus.CELL_STB_o  = cell_stb_r;
  assign bus.FRAME_END_o = frame_end_r;
  assign bus.VRAM_RAs_o  = ra_r;
  assign bus.FONT_ROWs_o = font_row_r;
  assign bus.FONT_BITs_o = font_bit_r;
endmodule

// File: tb/tb_osd_cell_seq.sv
// Directed bench for osd_cell_seq on a 4x2 grid of 8x8 glyphs; each line is
// driven cycle by cycle and window timing/addresses are captured per line.
module tb_osd_cell_seq;
  localparam int C_COLS = 4, C_ROWS = 2, C_FONT_W = 8, C_FONT_H = 8;
  localparam int C_HDLY_W = 12, C_VDLY_W = 11;

  logic ck = 1'b0;
  logic sys_r;
  always #5 ck = ~ck;

  osd_cell_seq_if #(.C_COLS(C_COLS), .C_ROWS(C_ROWS), .C_FONT_W(C_FONT_W),
                    .C_FONT_H(C_FONT_H), .C_HDLY_W(C_HDLY_W), .C_VDLY_W(C_VDLY_W)) bus ();

  osd_cell_seq #(.C_COLS(C_COLS), .C_ROWS(C_ROWS), .C_FONT_W(C_FONT_W),
                 .C_FONT_H(C_FONT_H), .C_HDLY_W(C_HDLY_W), .C_VDLY_W(C_VDLY_W)) dut (
    .CK_i(ck), .SYS_R_i(sys_r), .bus(bus));

  int errors = 0;
  int checks = 0;
  int first_act, last_act, act_len, stb_cnt, first_frow, fe_k, fe_cnt;
  int ra_q[$];
  int bit_q[$];
  int fe_line, fe_at, act_lines, first_line, last_line, verr, berr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic set_cfg(input int hd, input int vd, input int hm, input int vm,
                         input int hs, input int vs);
    bus.BUS_H_DLYs_i    = C_HDLY_W'(hd);
    bus.BUS_V_DLYs_i    = C_VDLY_W'(vd);
    bus.BUS_H_MAGs_i    = 3'(hm);
    bus.BUS_V_MAGs_i    = 3'(vm);
    bus.BUS_H_SCROLLs_i = 2'(hs);
    bus.BUS_V_SCROLLs_i = 1'(vs);
  endtask

  // One line: HSTART (optionally with VSTART), then ncyc-1 observed cycles.
  task automatic do_line(input bit vs, input bit tog, input int ncyc,
                         input int off_lo, input int off_hi);
    first_act = -1; last_act = -1; act_len = 0; stb_cnt = 0;
    first_frow = -1; fe_k = -1;
    ra_q.delete(); bit_q.delete();
    bus.HSTART_i = 1'b1; bus.VSTART_i = vs; bus.PIX_EN_i = 1'b1;
    tick();
    bus.HSTART_i = 1'b0; bus.VSTART_i = 1'b0;
    for (int k = 1; k < ncyc; k++) begin
      if (bus.ACT_o) begin
        if (first_act < 0) begin
          first_act  = k;
          first_frow = int'(bus.FONT_ROWs_o);
        end
        last_act = k;
        act_len++;
        bit_q.push_back(int'(bus.FONT_BITs_o));
      end
      if (bus.CELL_STB_o) begin
        stb_cnt++;
        ra_q.push_back(int'(bus.VRAM_RAs_o));
      end
      if (bus.FRAME_END_o) begin
        fe_cnt++;
        fe_k = k;
      end
      bus.PIX_EN_i      = tog ? (k % 2 == 0) : 1'b1;
      bus.BUS_OSD_OFF_i = (k >= off_lo) && (k < off_hi);
      tick();
    end
    bus.PIX_EN_i = 1'b1; bus.BUS_OSD_OFF_i = 1'b0;
  endtask

  function automatic int ra_at(input int i);
    return (i < ra_q.size()) ? ra_q[i] : -1;
  endfunction

  initial begin
    sys_r = 1'b1;
    bus.HSTART_i = 1'b0; bus.VSTART_i = 1'b0; bus.PIX_EN_i = 1'b1; bus.BUS_OSD_OFF_i = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_val("rst_act", bus.ACT_o, 0);
    check_val("rst_stb", bus.CELL_STB_o, 0);
    check_val("rst_fend", bus.FRAME_END_o, 0);
    check_val("rst_ra", bus.VRAM_RAs_o, 0);
    check_val("rst_frow", bus.FONT_ROWs_o, 0);
    check_val("rst_fbit", bus.FONT_BITs_o, 0);
    sys_r = 1'b0;

    // Unit magnification, no delay
    do_line(1'b1, 1'b0, 60, 0, 0);
    check_val("base_first", first_act, 2);
    check_val("base_len", act_len, 32);
    check_val("base_contig", last_act - first_act + 1, 32);
    check_val("base_stb", stb_cnt, 4);
    for (int i = 0; i < 4; i++) check_val("base_ra", ra_at(i), i);
    check_val("base_frow", first_frow, 0);

    // Horizontal magnification 3, delay 5
    set_cfg(5, 0, 2, 0, 0, 0);
    do_line(1'b1, 1'b0, 120, 0, 0);
    check_val("hmag_first", first_act, 7);
    check_val("hmag_len", act_len, 96);
    berr = 0;
    foreach (bit_q[i]) if (bit_q[i] != (i / 3) % 8) berr++;
    check_val("hmag_bits", berr, 0);
    check_val("hmag_stb", stb_cnt, 4);

    // Scroll wrap
    set_cfg(0, 0, 0, 0, 3, 1);
    do_line(1'b1, 1'b0, 60, 0, 0);
    check_val("scr_ra0", ra_at(0), 7);
    check_val("scr_ra1", ra_at(1), 4);
    check_val("scr_ra2", ra_at(2), 5);
    check_val("scr_ra3", ra_at(3), 6);

    // Pixel enable toggling
    set_cfg(0, 0, 0, 0, 0, 0);
    do_line(1'b1, 1'b1, 120, 0, 0);
    check_val("tog_first", first_act, 3);
    check_val("tog_len", act_len, 64);
    berr = 0;
    foreach (bit_q[i]) if (bit_q[i] != (i / 2) % 8) berr++;
    check_val("tog_bits", berr, 0);

    // Vertical delay 2, magnification 2, 40 lines
    set_cfg(0, 2, 0, 1, 0, 0);
    fe_cnt = 0; fe_line = -1; fe_at = -1; act_lines = 0;
    first_line = -1; last_line = -1; verr = 0;
    for (int ln = 0; ln < 40; ln++) begin
      do_line(ln == 0, 1'b0, 40, 0, 0);
      if (fe_k >= 0) begin
        fe_line = ln;
        fe_at   = fe_k;
      end
      if (act_len > 0) begin
        act_lines++;
        if (first_line < 0) first_line = ln;
        last_line = ln;
        if (first_frow != ((ln - 2) / 2) % 8) verr++;
        if (ra_at(0) != ((ln - 2) / 16) * 4) verr++;
      end
    end
    check_val("v_lines", act_lines, 32);
    check_val("v_first", first_line, 2);
    check_val("v_last", last_line, 33);
    check_val("v_frow_ra", verr, 0);
    check_val("v_fend_cnt", fe_cnt, 1);
    check_val("v_fend_line", fe_line, 34);
    check_val("v_fend_cyc", fe_at, 1);

    // OSD off masks output while counters keep running
    set_cfg(0, 0, 0, 0, 0, 0);
    do_line(1'b1, 1'b0, 60, 10, 20);
    check_val("off_len", act_len, 22);
    check_val("off_stb", stb_cnt, 3);
    check_val("off_ra2", ra_at(2), 3);

    // Reset in the middle of an active window
    bus.HSTART_i = 1'b1; bus.VSTART_i = 1'b1; bus.PIX_EN_i = 1'b1;
    tick();
    bus.HSTART_i = 1'b0; bus.VSTART_i = 1'b0;
    repeat (12) tick();
    check_val("mid_act", bus.ACT_o, 1);
    check_val("mid_ra", bus.VRAM_RAs_o, 1);
    check_val("mid_fbit", bus.FONT_BITs_o, 3);
    sys_r = 1'b1;
    tick();
    sys_r = 1'b0;
    check_val("mrst_act", bus.ACT_o, 0);
    check_val("mrst_ra", bus.VRAM_RAs_o, 0);
    check_val("mrst_fbit", bus.FONT_BITs_o, 0);
    check_val("mrst_stb", bus.CELL_STB_o, 0);
    do_line(1'b0, 1'b0, 60, 0, 0);
    check_val("mrst_nowin", act_len, 0);
    do_line(1'b1, 1'b0, 60, 0, 0);
    check_val("mrst_resume", act_len, 32);
    set_cfg(0, 0, 2, 2, 0, 0);
    do_line(1'b0, 1'b0, 120, 0, 0);
    check_val("mag_latched", act_len, 32);
    do_line(1'b1, 1'b0, 120, 0, 0);
    check_val("mag_newfield", act_len, 96);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
